// File: rtl/uart_boot_ctrl_if.sv
// Signal bundle between the boot sequencer and its UART, RAM write port and CPU core.
interface uart_boot_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdat;
    logic        ram_we;
    logic        cpu_reset;
    logic        boot_done;
    logic        boot_err;

    modport master (
        input  rx_data, rx_valid, tx_busy,
        output tx_data, tx_start, ram_addr, ram_wdat, ram_we,
        output cpu_reset, boot_done, boot_err
    );

    modport slave (
        output rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start, ram_addr, ram_wdat, ram_we,
        input  cpu_reset, boot_done, boot_err
    );
endinterface

// File: rtl/uart_boot_ctrl.sv
// Serial boot loader: holds the 6502 in reset, writes downloaded records into RAM,
// ACKs/NAKs each record and releases the CPU on a go record or on boot timeout.
module uart_boot_ctrl #(
    parameter logic [23:0] BOOT_TO  = 24'd12_000_000,
    parameter logic [15:0] BYTE_TO  = 16'd12_000,
    parameter logic [7:0]  ACK_BYTE = 8'h06,
    parameter logic [7:0]  NAK_BYTE = 8'h15
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_boot_ctrl_if.master bus
);
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [3:0] {
        S_WAIT_SYNC = 4'd0,
        S_ADDR_H    = 4'd1,
        S_ADDR_L    = 4'd2,
        S_LEN_H     = 4'd3,
        S_LEN_L     = 4'd4,
        S_DATA      = 4'd5,
        S_CSUM      = 4'd6,
        S_SEND      = 4'd7,
        S_SEND_WAIT = 4'd8,
        S_RUN       = 4'd9
    } state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] boot_cnt_q, boot_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        accepted_q, accepted_d;
    logic        zero_len_q, zero_len_d;
    logic        go_q, go_d;
    logic        skip_q, skip_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdat_q, ram_wdat_d;
    logic        ram_we_q, ram_we_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        boot_done_q, boot_done_d;
    logic        boot_err_q, boot_err_d;
    logic [15:0] len_full_s;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        csum_d      = csum_q;
        boot_cnt_d  = boot_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        accepted_d  = accepted_q;
        zero_len_d  = zero_len_q;
        go_d        = go_q;
        skip_d      = skip_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdat_d  = ram_wdat_q;
        ram_we_d    = 1'b0;
        boot_err_d  = boot_err_q;
        len_full_s  = {len_q[15:8], bus.rx_data};

        case (state_q)
            S_WAIT_SYNC: begin
                if (!accepted_q) begin
                    boot_cnt_d = boot_cnt_q + 24'd1;
                end else begin
                    boot_cnt_d = boot_cnt_q;
                end
                // A sync byte wins over a boot timeout landing in the same cycle.
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    csum_d     = 8'h00;
                    idle_cnt_d = 16'd0;
                    state_d    = S_ADDR_H;
                end else if (!accepted_q && ((boot_cnt_q + 24'd1) == BOOT_TO)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_WAIT_SYNC;
                end
            end

            S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM: begin
                if (bus.rx_valid) begin
                    idle_cnt_d = 16'd0;
                    csum_d     = csum_add(csum_q, bus.rx_data);
                    case (state_q)
                        S_ADDR_H: begin
                            ptr_d[15:8] = bus.rx_data;
                            state_d     = S_ADDR_L;
                        end
                        S_ADDR_L: begin
                            ptr_d[7:0] = bus.rx_data;
                            state_d    = S_LEN_H;
                        end
                        S_LEN_H: begin
                            len_d[15:8] = bus.rx_data;
                            state_d     = S_LEN_L;
                        end
                        S_LEN_L: begin
                            len_d      = len_full_s;
                            zero_len_d = (len_full_s == 16'd0);
                            state_d    = (len_full_s == 16'd0) ? S_CSUM : S_DATA;
                        end
                        S_DATA: begin
                            ram_we_d   = 1'b1;
                            ram_wdat_d = bus.rx_data;
                            ram_addr_d = ptr_q;
                            ptr_d      = ptr_q + 16'd1;
                            len_d      = len_q - 16'd1;
                            state_d    = (len_q == 16'd1) ? S_CSUM : S_DATA;
                        end
                        S_CSUM: begin
                            if (bus.rx_data == csum_q) begin
                                tx_data_d  = ACK_BYTE;
                                accepted_d = 1'b1;
                                go_d       = zero_len_q;
                            end else begin
                                tx_data_d  = NAK_BYTE;
                                boot_err_d = 1'b1;
                                go_d       = 1'b0;
                            end
                            state_d = S_SEND;
                        end
                        default: state_d = S_WAIT_SYNC;
                    endcase
                end else if ((idle_cnt_q + 16'd1) == BYTE_TO) begin
                    idle_cnt_d = 16'd0;
                    tx_data_d  = NAK_BYTE;
                    boot_err_d = 1'b1;
                    go_d       = 1'b0;
                    state_d    = S_SEND;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end

            S_SEND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    skip_d     = 1'b1;
                    state_d    = S_SEND_WAIT;
                end else begin
                    state_d = S_SEND;
                end
            end

            // The first cycle is skipped because tx_busy only rises after tx_start.
            S_SEND_WAIT: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    state_d = go_q ? S_RUN : S_WAIT_SYNC;
                end else begin
                    state_d = S_SEND_WAIT;
                end
            end

            S_RUN: state_d = S_RUN;

            default: state_d = S_WAIT_SYNC;
        endcase

        cpu_reset_d = (state_d != S_RUN);
        boot_done_d = (state_d == S_RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WAIT_SYNC;
            ptr_q       <= 16'd0;
            len_q       <= 16'd0;
            csum_q      <= 8'd0;
            boot_cnt_q  <= 24'd0;
            idle_cnt_q  <= 16'd0;
            accepted_q  <= 1'b0;
            zero_len_q  <= 1'b0;
            go_q        <= 1'b0;
            skip_q      <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_start_q  <= 1'b0;
            ram_addr_q  <= 16'd0;
            ram_wdat_q  <= 8'd0;
            ram_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            boot_cnt_q  <= boot_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            accepted_q  <= accepted_d;
            zero_len_q  <= zero_len_d;
            go_q        <= go_d;
            skip_q      <= skip_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdat_q  <= ram_wdat_d;
            ram_we_q    <= ram_we_d;
            cpu_reset_q <= cpu_reset_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdat  = ram_wdat_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.boot_done = boot_done_q;
    assign bus.boot_err  = boot_err_q;
endmodule
